sky130_fd_io__xres_seq_ctrl: RTL and testbench

SKY130_FD_IO__XRES_SEQ_CTRL -- requirements
Module: sky130_fd_io__xres_seq_ctrl

---
 rtl/sky130_fd_io__xres_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_sky130_fd_io__xres_seq_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sky130_fd_io__xres_seq_ctrl.sv
// XRES pad power sequencer: orders ENABLE_VDDIO/ENABLE_H, latches pad modes while OFF,
// and turns the pad reset level into a filtered, stretched system reset.
module sky130_fd_io__xres_seq_ctrl #(
   parameter int unsigned SEQ_GAP        = 4,
   parameter int unsigned FILT_CYCLES    = 16,
   parameter int unsigned STRETCH_CYCLES = 64
) (
   input  logic CLK,
   input  logic RESET_B,
   input  logic REQ_ON,
   input  logic VCCHIB_MODE,
   input  logic USE_FILT,
   input  logic XRES_H_N,
   output logic ENABLE_VDDIO,
   output logic ENABLE_H,
   output logic EN_VDDIO_SIG_H,
   output logic INP_SEL_H,
   output logic DISABLE_PULLUP_H,
   output logic READY,
   output logic SYS_RST_N,
   output logic GLITCH
);

   localparam logic [7:0]  GapLoad     = 8'(SEQ_GAP);
   localparam logic [7:0]  FiltLast    = 8'(FILT_CYCLES - 1);
   localparam logic [15:0] StretchLoad = 16'(STRETCH_CYCLES);

   typedef enum logic [1:0] {StOff, StVddioUp, StActive, StHDown} state_e;

   state_e      state;
   logic [7:0]  gap_cnt;
   logic        sync1, sync2, filt;
   logic [7:0]  fcnt;
   logic [15:0] stretch;
   logic        run, mismatch, accept;

   always_ff @(posedge CLK) begin
      if (!RESET_B) begin
         state            <= StOff;
         gap_cnt          <= 8'd0;
         ENABLE_VDDIO     <= 1'b0;
         ENABLE_H         <= 1'b0;
         EN_VDDIO_SIG_H   <= 1'b1;
         INP_SEL_H        <= 1'b0;
         DISABLE_PULLUP_H <= 1'b0;
         READY            <= 1'b0;
      end else begin
         unique case (state)
            StOff: begin
               EN_VDDIO_SIG_H <= !VCCHIB_MODE;
               INP_SEL_H      <= USE_FILT;
               if (REQ_ON) begin
                  state            <= StVddioUp;
                  gap_cnt          <= GapLoad;
                  ENABLE_VDDIO     <= 1'b1;
                  DISABLE_PULLUP_H <= 1'b1;
               end
            end
            StVddioUp: begin
               if (!REQ_ON) begin
                  state   <= StHDown;
                  gap_cnt <= GapLoad;
               end else if (gap_cnt == 8'd0) begin
                  state            <= StActive;
                  ENABLE_H         <= 1'b1;
                  READY            <= 1'b1;
                  DISABLE_PULLUP_H <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt - 8'd1;
               end
            end
            StActive: begin
               if (!REQ_ON) begin
                  state            <= StHDown;
                  gap_cnt          <= GapLoad;
                  ENABLE_H         <= 1'b0;
                  READY            <= 1'b0;
                  DISABLE_PULLUP_H <= 1'b1;
               end
            end
            StHDown: begin
               // REQ_ON is deliberately ignored here; a new power-up starts from OFF
               if (gap_cnt == 8'd0) begin
                  state            <= StOff;
                  ENABLE_VDDIO     <= 1'b0;
                  DISABLE_PULLUP_H <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt - 8'd1;
               end
            end
            default: state <= StOff;
         endcase
      end
   end

   // Filter only runs while staying in ACTIVE, so leaving ACTIVE clears it on the same edge
   assign run      = (state == StActive) && REQ_ON;
   assign mismatch = sync2 != filt;
   assign accept   = mismatch && (fcnt == FiltLast);

   always_ff @(posedge CLK) begin
      if (!RESET_B || !run) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         filt      <= 1'b0;
         fcnt      <= 8'd0;
         stretch   <= 16'd0;
         SYS_RST_N <= 1'b0;
         GLITCH    <= 1'b0;
      end else begin
         sync1  <= XRES_H_N;
         sync2  <= sync1;
         GLITCH <= 1'b0;
         if (accept) begin
            filt      <= sync2;
            fcnt      <= 8'd0;
            stretch   <= sync2 ? StretchLoad : 16'd0;
            SYS_RST_N <= 1'b0;
         end else begin
            if (mismatch) begin
               fcnt <= fcnt + 8'd1;
            end else if (fcnt != 8'd0) begin
               fcnt   <= 8'd0;
               GLITCH <= 1'b1;
            end
            if (stretch != 16'd0) begin
               stretch <= stretch - 16'd1;
               if (stretch == 16'd1) SYS_RST_N <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sky130_fd_io__xres_seq_ctrl.sv
// Directed bench for the XRES sequencer: power sequencing, filter latency, glitch rejection,
// mode latching, power-down ordering and mid-sequence reset.
module tb_sky130_fd_io__xres_seq_ctrl;

   logic clk = 1'b0;
   logic rst_b, req_on, vcchib, use_filt, xres;
   logic enable_vddio, enable_h, en_sig, inp_sel, dis_pu, ready, sys_rst_n, glitch;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sky130_fd_io__xres_seq_ctrl dut (
      .CLK              (clk),
      .RESET_B          (rst_b),
      .REQ_ON           (req_on),
      .VCCHIB_MODE      (vcchib),
      .USE_FILT         (use_filt),
      .XRES_H_N         (xres),
      .ENABLE_VDDIO     (enable_vddio),
      .ENABLE_H         (enable_h),
      .EN_VDDIO_SIG_H   (en_sig),
      .INP_SEL_H        (inp_sel),
      .DISABLE_PULLUP_H (dis_pu),
      .READY            (ready),
      .SYS_RST_N        (sys_rst_n),
      .GLITCH           (glitch)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_enable_vddio"}, enable_vddio, 0);
      check_eq({tag, "_enable_h"}, enable_h, 0);
      check_eq({tag, "_en_vddio_sig"}, en_sig, 1);
      check_eq({tag, "_inp_sel"}, inp_sel, 0);
      check_eq({tag, "_dis_pullup"}, dis_pu, 0);
      check_eq({tag, "_ready"}, ready, 0);
      check_eq({tag, "_sys_rst_n"}, sys_rst_n, 0);
      check_eq({tag, "_glitch"}, glitch, 0);
   endtask

   // Ordering monitor: ENABLE_H needs ENABLE_VDDIO and a gap of at least 4 cycles either side
   logic mon_en = 1'b0;
   int   mon_viol = 0;
   int   v_rise_age = 1000;
   int   h_fall_age = 1000;
   logic prev_h = 1'b0, prev_v = 1'b0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (enable_h && !enable_vddio) mon_viol++;
         if (enable_h && !prev_h && v_rise_age < 4) mon_viol++;
         if (!enable_vddio && prev_v && h_fall_age < 4) mon_viol++;
         v_rise_age = (enable_vddio && !prev_v) ? 0 : v_rise_age + 1;
         h_fall_age = (!enable_h && prev_h) ? 0 : h_fall_age + 1;
      end
      prev_h = enable_h;
      prev_v = enable_vddio;
   end

   initial begin
      int gcnt, gedge, lows, first_low, first_high, vfall, waited;
      rst_b = 1'b0; req_on = 1'b0; vcchib = 1'b0; use_filt = 1'b0; xres = 1'b1;
      tick(2);
      check_reset_outputs("reset");

      rst_b = 1'b1;
      tick(1);
      mon_en = 1'b1;
      vcchib = 1'b1; use_filt = 1'b1;
      tick(1);
      check_eq("off_latch_en_sig", en_sig, 0);
      check_eq("off_latch_inp_sel", inp_sel, 1);

      // Power-up: VDDIO at edge 1, H and READY at edge 6
      req_on = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         tick(1);
         check_eq($sformatf("up_e%0d_enable_vddio", e), enable_vddio, 1);
         check_eq($sformatf("up_e%0d_enable_h", e), enable_h, (e == 6) ? 1 : 0);
      end
      check_eq("up_ready", ready, 1);
      check_eq("up_dis_pullup", dis_pu, 0);

      // Mode change in ACTIVE must not reach the pad; reset release needs 82 edges
      vcchib = 1'b0;
      tick(81);
      check_eq("stretch_e81_sys_rst_n", sys_rst_n, 0);
      tick(1);
      check_eq("stretch_e82_sys_rst_n", sys_rst_n, 1);
      check_eq("active_en_sig_held", en_sig, 0);

      // 10-cycle low pulse is rejected with a single GLITCH at edge 13
      gcnt = 0; gedge = 0; lows = 0;
      xres = 1'b0;
      for (int i = 1; i <= 25; i++) begin
         tick(1);
         if (glitch) begin gcnt++; gedge = i; end
         if (!sys_rst_n) lows++;
         if (i == 10) xres = 1'b1;
      end
      check_eq("short_pulse_glitch_count", gcnt, 1);
      check_eq("short_pulse_glitch_edge", gedge, 13);
      check_eq("short_pulse_sys_low", lows, 0);

      // 20-cycle low is accepted at edge 18; release returns 82 edges after edge 20
      gcnt = 0; first_low = 0; first_high = 0;
      xres = 1'b0;
      for (int i = 1; i <= 110; i++) begin
         tick(1);
         if (glitch) gcnt++;
         if (!sys_rst_n && first_low == 0) first_low = i;
         if (sys_rst_n && first_low != 0 && first_high == 0) first_high = i;
         if (i == 20) xres = 1'b1;
      end
      check_eq("long_pulse_assert_edge", first_low, 18);
      check_eq("long_pulse_release_edge", first_high, 102);
      check_eq("long_pulse_glitch_count", gcnt, 0);

      // Power-down with REQ_ON re-raised during H_DOWN
      req_on = 1'b0;
      vfall = 0;
      for (int e = 1; e <= 12; e++) begin
         tick(1);
         if (e == 1) begin
            check_eq("down_e1_enable_h", enable_h, 0);
            check_eq("down_e1_enable_vddio", enable_vddio, 1);
            check_eq("down_e1_sys_rst_n", sys_rst_n, 0);
            check_eq("down_e1_ready", ready, 0);
            check_eq("down_e1_dis_pullup", dis_pu, 1);
            req_on = 1'b1;
         end
         if (!enable_vddio && vfall == 0) vfall = e;
         if (e == 6) check_eq("down_e6_en_sig", en_sig, 0);
         if (e == 7) begin
            check_eq("reup_e7_enable_vddio", enable_vddio, 1);
            check_eq("reup_e7_en_sig", en_sig, 1);
         end
         if (e == 12) check_eq("reup_e12_enable_h", enable_h, 1);
      end
      check_eq("down_vddio_fall_edge", vfall, 6);

      // Random REQ_ON toggling under the ordering monitor
      vcchib = 1'b1; use_filt = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) == 0) req_on = ~req_on;
         tick(1);
      end
      req_on = 1'b1;
      waited = 0;
      while (!(ready && sys_rst_n) && waited < 200) begin
         tick(1);
         waited++;
      end
      check_eq("pre_reset_active_timeout", {31'd0, ready && sys_rst_n}, 1);
      check_eq("pre_reset_en_sig", en_sig, 0);
      check_eq("seq_order_violations", mon_viol, 0);

      // Reset in ACTIVE drops everything on one edge
      mon_en = 1'b0;
      rst_b = 1'b0;
      tick(1);
      check_reset_outputs("mid_reset");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
